// File: rtl/four_bit_1x2_demux_reg_pkg.sv
// rtl/four_bit_1x2_demux_reg_pkg.sv - shared constants, occupancy type and saturating helper
//
// Purpose: common definitions for the registered 1-to-2 demultiplexer.
//   DEMUX_WIDTH : default data width
//   CH0 / CH1   : channel index values carried on Select
//   occ_e       : per-channel FIFO occupancy (derived from pointers)
//   sat_inc     : increment that holds at a ceiling instead of wrapping
package four_bit_1x2_demux_reg_pkg;

  localparam int DEMUX_WIDTH = 4;

  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;

  typedef enum logic [1:0] {
    OCC_EMPTY   = 2'd0,
    OCC_PARTIAL = 2'd1,
    OCC_FULL    = 2'd2
  } occ_e;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
    return (v >= max_v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/four_bit_1x2_demux_reg_chan_fifo.sv
// rtl/four_bit_1x2_demux_reg_chan_fifo.sv - per-channel FIFO with wrap-bit pointers
//
// Purpose: small synchronous FIFO for one demux output channel.
// Ports:
//   Clock, Reset_n : clock, asynchronous active-low reset (empties the FIFO)
//   push, push_data: write request and data (ignored when full)
//   pop            : remove head (ignored when empty)
//   head           : head entry, 0 when empty
//   empty, full    : occupancy flags from registered pointers
//   count          : current number of entries
module demux_chan_fifo
  import four_bit_1x2_demux_reg_pkg::*;
#(
  parameter int WIDTH = DEMUX_WIDTH,
  parameter int DEPTH = 2,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full,
  output logic [AW:0]      count
);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  occ_e             occ;
  logic             push_ok;
  logic             pop_ok;

  always_comb begin
    occ = OCC_PARTIAL;
    if (wr_q == rd_q) begin
      occ = OCC_EMPTY;
    end else if ((wr_q[AW-1:0] == rd_q[AW-1:0]) && (wr_q[AW] != rd_q[AW])) begin
      occ = OCC_FULL;
    end
  end

  assign empty   = (occ == OCC_EMPTY);
  assign full    = (occ == OCC_FULL);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign wr_d    = wr_q + {{AW{1'b0}}, push_ok};
  assign rd_d    = rd_q + {{AW{1'b0}}, pop_ok};
  assign count   = wr_q - rd_q;
  assign head    = empty ? '0 : mem_q[rd_q[AW-1:0]];

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage needs no reset: entries are only visible between rd and wr pointers.
  always_ff @(posedge Clock) begin
    if (push_ok) begin
      mem_q[wr_q[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/four_bit_1x2_demux_reg.sv
// rtl/four_bit_1x2_demux_reg.sv - registered 1-to-2 demux with per-channel FIFOs and counters
//
// Purpose: steer one valid/ready input stream to one of two buffered outputs.
// Ports:
//   Clock, Reset_n        : clock, asynchronous active-low reset
//   In, In_Valid, In_Ready: producer stream; Select picks the channel
//   Out_k, Out_k_Valid    : head word and non-empty flag of channel k
//   Out_k_Ready           : consumer k takes the head
//   Clear                 : synchronous clear of both delivered-word counters
//   Count_k               : saturating count of words popped from channel k
module four_bit_1x2_demux_reg
  import four_bit_1x2_demux_reg_pkg::*;
#(
  parameter int WIDTH = DEMUX_WIDTH,
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic [WIDTH-1:0] In,
  input  logic             In_Valid,
  output logic             In_Ready,
  input  logic             Select,
  output logic [WIDTH-1:0] Out_0,
  output logic             Out_0_Valid,
  input  logic             Out_0_Ready,
  output logic [WIDTH-1:0] Out_1,
  output logic             Out_1_Valid,
  input  logic             Out_1_Ready,
  input  logic             Clear,
  output logic [CNT_W-1:0] Count_0,
  output logic [CNT_W-1:0] Count_1
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] OCC_MAX = (AW+1)'(DEPTH);
  localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

  logic             empty0, empty1;
  logic             full0, full1;
  logic [AW:0]      occ0, occ1;
  logic             push0, push1;
  logic             pop0, pop1;
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;

  // Ready depends only on Select and registered full flags, never on Out_k_Ready.
  assign In_Ready = Reset_n && !((Select == CH1) ? full1 : full0);
  assign push0    = In_Valid && In_Ready && (Select == CH0);
  assign push1    = In_Valid && In_Ready && (Select == CH1);
  assign pop0     = Out_0_Ready && !empty0;
  assign pop1     = Out_1_Ready && !empty1;

  demux_chan_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo0 (
    .Clock     (Clock),
    .Reset_n   (Reset_n),
    .push      (push0),
    .push_data (In),
    .pop       (pop0),
    .head      (Out_0),
    .empty     (empty0),
    .full      (full0),
    .count     (occ0)
  );

  demux_chan_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
    .Clock     (Clock),
    .Reset_n   (Reset_n),
    .push      (push1),
    .push_data (In),
    .pop       (pop1),
    .head      (Out_1),
    .empty     (empty1),
    .full      (full1),
    .count     (occ1)
  );

  assign Out_0_Valid = !empty0;
  assign Out_1_Valid = !empty1;

  // Clear has priority over a same-cycle pop.
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (Clear) begin
      cnt0_d = '0;
      cnt1_d = '0;
    end else begin
      if (pop0) cnt0_d = CNT_W'(sat_inc(32'(cnt0_q), CNT_MAX));
      if (pop1) cnt1_d = CNT_W'(sat_inc(32'(cnt1_q), CNT_MAX));
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign Count_0 = cnt0_q;
  assign Count_1 = cnt1_q;

  always_ff @(posedge Clock) begin
    if (Reset_n) begin
      assert (occ0 <= OCC_MAX && occ1 <= OCC_MAX);
    end
  end

endmodule

// File: tb/tb_four_bit_1x2_demux_reg.sv
// tb/tb_four_bit_1x2_demux_reg.sv - scoreboard bench for the registered 1-to-2 demux
module tb_four_bit_1x2_demux_reg;

  localparam int DEPTH = 2;
  localparam int CMAX  = 255;

  logic       Clock = 1'b0;
  logic       Reset_n;
  logic [3:0] In;
  logic       In_Valid;
  logic       In_Ready;
  logic       Select;
  logic [3:0] Out_0;
  logic       Out_0_Valid;
  logic       Out_0_Ready;
  logic [3:0] Out_1;
  logic       Out_1_Valid;
  logic       Out_1_Ready;
  logic       Clear;
  logic [7:0] Count_0;
  logic [7:0] Count_1;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: one queue of expected words per channel plus counters.
  logic [3:0] q0[$];
  logic [3:0] q1[$];
  int         m_cnt0 = 0;
  int         m_cnt1 = 0;
  logic       mon_en = 1'b0;

  always #5 Clock = ~Clock;

  four_bit_1x2_demux_reg dut (
    .Clock       (Clock),
    .Reset_n     (Reset_n),
    .In          (In),
    .In_Valid    (In_Valid),
    .In_Ready    (In_Ready),
    .Select      (Select),
    .Out_0       (Out_0),
    .Out_0_Valid (Out_0_Valid),
    .Out_0_Ready (Out_0_Ready),
    .Out_1       (Out_1),
    .Out_1_Valid (Out_1_Valid),
    .Out_1_Ready (Out_1_Ready),
    .Clear       (Clear),
    .Count_0     (Count_0),
    .Count_1     (Count_1)
  );

  function automatic void chk(input string nm, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endfunction

  // Monitor: compares every visible output against the model away from the active edge.
  always @(negedge Clock) begin
    if (mon_en) begin
      int sz;
      sz = (Select ? q1.size() : q0.size());
      chk("in_ready", int'(In_Ready), int'(Reset_n && (sz < DEPTH)));
      chk("out0_valid", int'(Out_0_Valid), int'(q0.size() > 0));
      chk("out1_valid", int'(Out_1_Valid), int'(q1.size() > 0));
      chk("out0_data", int'(Out_0), (q0.size() > 0) ? int'(q0[0]) : 0);
      chk("out1_data", int'(Out_1), (q1.size() > 0) ? int'(q1[0]) : 0);
      chk("count0", int'(Count_0), m_cnt0);
      chk("count1", int'(Count_1), m_cnt1);
    end
  end

  // Drive one cycle of stimulus and advance the model across the rising edge.
  task automatic step(input logic v, input logic s, input logic [3:0] d,
                      input logic r0, input logic r1, input logic clr, output logic acc);
    logic       p0, p1;
    logic [3:0] junk;
    In_Valid = v; Select = s; In = d;
    Out_0_Ready = r0; Out_1_Ready = r1; Clear = clr;
    @(posedge Clock);
    acc = 1'b0;
    if (Reset_n) begin
      acc = v && ((s ? q1.size() : q0.size()) < DEPTH);
      p0  = r0 && (q0.size() > 0);
      p1  = r1 && (q1.size() > 0);
      if (p0) junk = q0.pop_front();
      if (p1) junk = q1.pop_front();
      if (acc) begin
        if (s) q1.push_back(d);
        else   q0.push_back(d);
      end
      if (clr) begin
        m_cnt0 = 0;
        m_cnt1 = 0;
      end else begin
        if (p0 && m_cnt0 < CMAX) m_cnt0++;
        if (p1 && m_cnt1 < CMAX) m_cnt1++;
      end
    end
    #1;
  endtask

  task automatic idle(input logic r0, input logic r1, input int n);
    logic a;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'h0, r0, r1, 1'b0, a);
  endtask

  initial begin
    logic a;
    int   tries;
    Reset_n = 1'b0; In = '0; In_Valid = 0; Select = 0;
    Out_0_Ready = 0; Out_1_Ready = 0; Clear = 0;
    mon_en = 1'b1;
    idle(1'b0, 1'b0, 3);
    Reset_n = 1'b1;
    #1;
    chk("rst_in_ready", int'(In_Ready), 1);
    chk("rst_out0_valid", int'(Out_0_Valid), 0);
    chk("rst_count0", int'(Count_0), 0);
    idle(1'b0, 1'b0, 2);

    // Single word to channel 0, one-cycle latency, counted after the pop.
    step(1'b1, 1'b0, 4'hA, 1'b1, 1'b1, 1'b0, a);
    chk("dir_out0", int'(Out_0), 10);
    chk("dir_out1_valid", int'(Out_1_Valid), 0);
    idle(1'b1, 1'b1, 1);
    chk("dir_count0", int'(Count_0), 1);

    // Stall channel 1 until full; channel 0 still accepts.
    step(1'b1, 1'b1, 4'h3, 1'b1, 1'b0, 1'b0, a);
    step(1'b1, 1'b1, 4'h5, 1'b1, 1'b0, 1'b0, a);
    In_Valid = 0; Select = 1; #1;
    chk("ch1_full_ready", int'(In_Ready), 0);
    chk("ch1_head", int'(Out_1), 3);
    step(1'b1, 1'b1, 4'h9, 1'b1, 1'b0, 1'b0, a);
    step(1'b1, 1'b0, 4'h7, 1'b0, 1'b0, 1'b0, a);
    idle(1'b0, 1'b1, 3);

    // Channel 0 full with pop and push together: push lands a cycle later.
    step(1'b1, 1'b0, 4'h8, 1'b0, 1'b0, 1'b0, a);
    step(1'b1, 1'b0, 4'h9, 1'b1, 1'b0, 1'b0, a);
    step(1'b1, 1'b0, 4'h9, 1'b1, 1'b0, 1'b0, a);
    idle(1'b1, 1'b1, 3);

    // Continuous traffic across pointer wrap.
    for (int i = 0; i < 16; i++) begin
      tries = 0;
      do begin
        step(1'b1, 1'b0, 4'(i), 1'b1, 1'b1, 1'b0, a);
        tries++;
      end while (!a && tries < 4);
      chk("wrap_accept", int'(a), 1);
    end
    idle(1'b1, 1'b1, 3);

    // Full sweep of data and select with both consumers ready.
    step(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, a);
    for (int s = 0; s < 2; s++)
      for (int d = 0; d < 16; d++)
        step(1'b1, 1'(s), 4'(d), 1'b1, 1'b1, 1'b0, a);
    idle(1'b1, 1'b1, 3);
    chk("sweep_count0", int'(Count_0), 16);
    chk("sweep_count1", int'(Count_1), 16);

    // Random traffic with independent stalls and occasional clears.
    for (int i = 0; i < 400; i++)
      step(1'($urandom), 1'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
           ($urandom_range(0, 15) == 0), a);
    idle(1'b1, 1'b1, 3);

    // Counter saturation.
    step(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, a);
    for (int i = 0; i < 270; i++) step(1'b1, 1'b0, 4'($urandom), 1'b1, 1'b1, 1'b0, a);
    idle(1'b1, 1'b1, 3);
    chk("sat_count0", int'(Count_0), 255);

    // Clear concurrent with a pop.
    step(1'b1, 1'b1, 4'hC, 1'b1, 1'b0, 1'b0, a);
    step(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, a);
    chk("clr_count1", int'(Count_1), 0);
    chk("clr_count0", int'(Count_0), 0);

    // Asynchronous reset with both FIFOs occupied.
    step(1'b1, 1'b0, 4'h1, 1'b0, 1'b0, 1'b0, a);
    step(1'b1, 1'b0, 4'h2, 1'b1, 1'b0, 1'b0, a);
    step(1'b1, 1'b1, 4'h3, 1'b0, 1'b0, 1'b0, a);
    chk("pre_rst_count0", int'(Count_0), 1);
    #2;
    Reset_n = 1'b0;
    q0.delete(); q1.delete(); m_cnt0 = 0; m_cnt1 = 0;
    #1;
    chk("arst_out0_valid", int'(Out_0_Valid), 0);
    chk("arst_out1_valid", int'(Out_1_Valid), 0);
    chk("arst_out1", int'(Out_1), 0);
    chk("arst_in_ready", int'(In_Ready), 0);
    chk("arst_count0", int'(Count_0), 0);
    idle(1'b1, 1'b1, 2);
    Reset_n = 1'b1;
    idle(1'b1, 1'b1, 3);
    chk("post_rst_out0_valid", int'(Out_0_Valid), 0);
    chk("post_rst_out1_valid", int'(Out_1_Valid), 0);

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
